// File: rtl/spi_buf_pkg.sv
// Shared types for the SPI buffer write arbiter:
// FSM states, requester ids and the default address width.
package spi_buf_pkg;

  localparam int ADDR_W_DEF = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    REQ_SPI  = 1'b0,
    REQ_HOST = 1'b1
  } req_t;

endpackage

// File: rtl/spi_buf_rr_grant.sv
// Two-requester round-robin grant with priority flop.
// Ports: clk, reset, req_spi/req_host in; gnt_spi/gnt_host out.
module spi_buf_rr_grant
  import spi_buf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_spi,
  input  logic req_host,
  output logic gnt_spi,
  output logic gnt_host
);

  req_t prio;

  // A lone requester always wins; on contention the
  // priority holder wins.
  always_comb begin
    gnt_spi  = req_spi && (!req_host || prio == REQ_SPI);
    gnt_host = req_host && !gnt_spi;
  end

  // Priority moves to the other side after any grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= REQ_SPI;
    end else if (gnt_spi) begin
      prio <= REQ_HOST;
    end else if (gnt_host) begin
      prio <= REQ_SPI;
    end
  end

endmodule

// File: rtl/spi_buf_write_arbiter.sv
// Arbitrates an SPI byte stream and host random writes onto one
// registered 8-bit RAM write port.
// Ports: Clk, Reset; SpiStart/SpiStartAddr/SpiLen; SpiValid/
// SpiData/SpiReady; HostValid/HostAddr/HostData/HostReady;
// RamWriteEnable/RamWriteAddr/RamWriteData; SpiBusy; SpiDone.
// Option SPI_BUF_HOST_PROTECT_EN: drops host writes inside the
// active stream window and adds the HostDropped pulse output.
module spi_buf_write_arbiter
  import spi_buf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              SpiStart,
  input  logic [ADDR_W-1:0] SpiStartAddr,
  input  logic [ADDR_W-1:0] SpiLen,
  input  logic              SpiValid,
  input  logic [7:0]        SpiData,
  output logic              SpiReady,
  input  logic              HostValid,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [7:0]        HostData,
  output logic              HostReady,
`ifdef SPI_BUF_HOST_PROTECT_EN
  output logic              HostDropped,
`endif
  output logic              RamWriteEnable,
  output logic [ADDR_W-1:0] RamWriteAddr,
  output logic [7:0]        RamWriteData,
  output logic              SpiBusy,
  output logic              SpiDone
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] rem_cnt;
  logic [ADDR_W-1:0] rem_n;
  logic              done_n;
  logic              req_spi;
  logic              req_host;
  logic              gnt_spi;
  logic              gnt_host;
  logic              host_drop;

  // A start pulse takes the cycle, so no stream byte that cycle.
  assign req_spi  = !Reset && state == RUN
                    && SpiValid && !SpiStart;
  assign req_host = !Reset && HostValid;

  spi_buf_rr_grant u_rr (
    .clk      (Clk),
    .reset    (Reset),
    .req_spi  (req_spi),
    .req_host (req_host),
    .gnt_spi  (gnt_spi),
    .gnt_host (gnt_host)
  );

  assign SpiReady  = gnt_spi;
  assign HostReady = gnt_host;
  assign SpiBusy   = (state == RUN);

`ifdef SPI_BUF_HOST_PROTECT_EN
  // addr_cnt + rem_cnt is always start + len, so the window
  // test reduces to a modular offset compare against rem_cnt.
  logic [ADDR_W-1:0] host_off;
  assign host_off  = HostAddr - addr_cnt;
  assign host_drop = (state == RUN) && (host_off <= rem_cnt);
`else
  assign host_drop = 1'b0;
`endif

  always_comb begin
    state_n = state;
    addr_n  = addr_cnt;
    rem_n   = rem_cnt;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (SpiStart) begin
          state_n = RUN;
          addr_n  = SpiStartAddr;
          rem_n   = SpiLen;
        end
      end
      RUN: begin
        if (SpiStart) begin
          addr_n = SpiStartAddr;
          rem_n  = SpiLen;
        end else if (gnt_spi) begin
          addr_n = addr_cnt + 1'b1;
          if (rem_cnt == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            rem_n = rem_cnt - 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_cnt       <= '0;
      rem_cnt        <= '0;
      SpiDone        <= 1'b0;
      RamWriteEnable <= 1'b0;
      RamWriteAddr   <= '0;
      RamWriteData   <= '0;
    end else begin
      addr_cnt       <= addr_n;
      rem_cnt        <= rem_n;
      SpiDone        <= done_n;
      RamWriteEnable <= 1'b0;
      if (gnt_spi) begin
        RamWriteEnable <= 1'b1;
        RamWriteAddr   <= addr_cnt;
        RamWriteData   <= SpiData;
      end else if (gnt_host && !host_drop) begin
        RamWriteEnable <= 1'b1;
        RamWriteAddr   <= HostAddr;
        RamWriteData   <= HostData;
      end
    end
  end

`ifdef SPI_BUF_HOST_PROTECT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HostDropped <= 1'b0;
    end else begin
      HostDropped <= gnt_host && host_drop;
    end
  end
`endif

endmodule
